lenet_result_checker: RTL and testbench
=======================================

# lenet_result_checker

Synthesizable, parametrised self-check engine that sits beside the LeNet accelerator and the activation SRAM in the FPGA/emulation top. It measures the compute latency from `compute_start` to `compute_finish` and enforces a cycle watchdog. After completion it streams the activation SRAM against a golden SRAM and reports per-layer-region error counts, the first mismatching address, and a pass/fail verdict. It replaces simulation-only checking with on-chip checking across any number of layer regions.

## Interface
- `DATA_W`, 32: SRAM word width.
- `ADDR_W`, 16: SRAM address width.
- `NUM_REGIONS`, 6: number of contiguous result regions (image, conv1–3, fc1–2).
- `CNT_W`, 16: width of each per-region error counter.
- `TIMEOUT`, 26000: watchdog limit in cycles.

- `clk` in 1: the single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `compute_start` in 1: one-cycle start pulse, shared with the accelerator.
- `compute_finish` in 1: accelerator completion level.
- `region_end` in NUM_REGIONS*ADDR_W: exclusive end address per region.
  - Slice i is bits [i*ADDR_W +: ADDR_W].
  - Region 0 starts at 0; region i starts at `region_end[i-1]`.
  - Values must be non-decreasing.
- `rd_en` out 1: read enable to both SRAMs.
- `act_addr` out ADDR_W: activation SRAM read address.
- `act_rdata` in DATA_W: activation read data, valid 1 cycle after address.
- `gold_addr` out ADDR_W: golden SRAM read address, always equal to `act_addr`.
- `gold_rdata` in DATA_W: golden read data, same latency as `act_rdata`.
- `cycle_count` out 32: compute latency in cycles.
- `err_count` out NUM_REGIONS*CNT_W: per-region mismatch counts.
- `first_err_valid` out 1: at least one mismatch was found.
- `first_err_addr` out ADDR_W: address of the first mismatch.
- `done` out 1: check complete (level).
- `pass` out 1: valid while `done`.
- `timeout` out 1: watchdog fired.

## Operation
- FSM states: IDLE, RUN, SCAN, DRAIN, DONE.
- IDLE or DONE, `compute_start`=1 → RUN.
  - Clears `cycle_count`, all `err_count`, `first_err_*`, `done`, `pass`, `timeout`.
- RUN:
  - `cycle_count` increments every cycle in RUN.
  - `compute_finish`=1 → SCAN, `act_addr`=0.
  - Otherwise, if `cycle_count`==TIMEOUT-1 → DONE with `timeout`=1, `pass`=0, no scan.
- SCAN:
  - `rd_en`=1; address advances by 1 per cycle up to N-1, where N = `region_end[NUM_REGIONS-1]`.
  - After issuing N-1 → DRAIN.
  - If N==0, SCAN goes directly to DONE with `pass`=1.
- DRAIN: `rd_en`=0; one cycle for the last compare → DONE.
- Compare pipeline:
  - The address and its region index are delayed one stage to align with rdata.
  - On `act_rdata != gold_rdata`, the region counter increments.
  - Counters saturate at all-ones.
  - The first mismatch latches `first_err_addr` and sets `first_err_valid`.
- Region index = smallest i with addr < `region_end[i]`. Empty regions (equal ends) keep a count of 0.
- DONE: `done`=1, `pass` = (no errors) and not `timeout`. Outputs hold until the next `compute_start`.
- `compute_start` in RUN, SCAN or DRAIN is ignored. `compute_finish` outside RUN is ignored.

## Timing
- Reset values: state IDLE, all outputs 0. This includes `done`, `pass`, `rd_en` and the addresses.
- `rst_n` low mid-operation aborts immediately to the reset values; there is no partial result.
- Start pulse sampled at edge e → RUN from e, first increment at e+1.
- `cycle_count` = number of edges spent in RUN, including the edge that samples `compute_finish`.
- Finish sampled at edge f → addresses 0..N-1 presented after edges f..f+N-1.
- The final counts and `done` both appear at edge f+N+1.
- Watchdog: `done` and `timeout` rise at the edge where `cycle_count` would reach TIMEOUT.

## Structure
- Package `lenet_chk_pkg`:
  - state enum;
  - default region ends {256, 592, 692, 722, 743, 753};
  - default TIMEOUT.
- Sub-module `chk_cmp_stage`:
  - the one-stage address/region delay;
  - the comparator;
  - the saturating per-region counters and first-error capture.
- The top holds the FSM, cycle counter, watchdog and address generator.

## Test plan
- Matching SRAMs, finish 500 cycles after start, default regions:
  - `cycle_count`=500;
  - all `err_count`=0;
  - `pass`=1;
  - `done` 754 edges after finish.
- Corrupt act words 300 and 700:
  - `err_count` region1=1, region3=1, others 0;
  - `first_err_addr`=300;
  - `pass`=0.
- Finish never asserted, TIMEOUT=100:
  - `done`=`timeout`=1 after 100 cycles;
  - `rd_en` never high.
- Region ends {0, 0, 4, 4, 4, 8}, all words differ:
  - counts {0, 0, 4, 0, 0, 4}.
- `rst_n` pulsed low mid-SCAN: all outputs 0 immediately. A subsequent start runs cleanly to `pass`=1.
- Second `compute_start` while in DONE clears the previous results. A start during SCAN is ignored; counts are unchanged.

Source files
------------

// File: rtl/lenet_chk_pkg.sv
// Shared types and defaults for the LeNet on-chip result checker.
// Default region ends cover the image, conv1-3 and fc1-2 activations.
package lenet_chk_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        SCAN,
        DRAIN,
        DONE
    } chk_state_t;

    localparam int DEFAULT_TIMEOUT     = 26000;
    localparam int DEFAULT_NUM_REGIONS = 6;
    localparam int DEFAULT_ADDR_W      = 16;

    // Slice 0 (lowest bits) is the end of the image region.
    localparam logic [DEFAULT_NUM_REGIONS*DEFAULT_ADDR_W-1:0] DEFAULT_REGION_END =
        {16'd753, 16'd743, 16'd722, 16'd692, 16'd592, 16'd256};

endpackage

// File: rtl/chk_cmp_stage.sv
// One-stage address/region delay aligned with SRAM read data, the word
// comparator, saturating per-region error counters and first-error capture.
module chk_cmp_stage
    import lenet_chk_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 16,
    parameter int NUM_REGIONS = 6,
    parameter int CNT_W       = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clear,
    input  logic                          rd_en,
    input  logic [ADDR_W-1:0]             addr,
    input  logic [NUM_REGIONS*ADDR_W-1:0] region_end,
    input  logic [DATA_W-1:0]             act_rdata,
    input  logic [DATA_W-1:0]             gold_rdata,
    output logic [NUM_REGIONS*CNT_W-1:0]  err_count,
    output logic                          first_err_valid,
    output logic [ADDR_W-1:0]             first_err_addr
);

    localparam int RIDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;

    logic [RIDX_W-1:0] ridx;
    logic [RIDX_W-1:0] ridx_d;
    logic              found;
    logic              valid_d;
    logic [ADDR_W-1:0] addr_d;
    logic              mismatch;
    logic [CNT_W-1:0]  cnt [NUM_REGIONS];

    // First region whose exclusive end lies above the address; empty regions never match.
    always_comb begin
        ridx  = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            if (!found && (addr < region_end[i*ADDR_W +: ADDR_W])) begin
                ridx  = RIDX_W'(i);
                found = 1'b1;
            end
        end
    end

    assign mismatch = valid_d && (act_rdata != gold_rdata);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_d         <= 1'b0;
            addr_d          <= '0;
            ridx_d          <= '0;
            first_err_valid <= 1'b0;
            first_err_addr  <= '0;
            for (int i = 0; i < NUM_REGIONS; i++) begin
                cnt[i] <= '0;
            end
        end else if (clear) begin
            valid_d         <= 1'b0;
            addr_d          <= '0;
            ridx_d          <= '0;
            first_err_valid <= 1'b0;
            first_err_addr  <= '0;
            for (int i = 0; i < NUM_REGIONS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            valid_d <= rd_en;
            addr_d  <= addr;
            ridx_d  <= ridx;
            for (int i = 0; i < NUM_REGIONS; i++) begin
                if (mismatch && (ridx_d == RIDX_W'(i)) && (cnt[i] != {CNT_W{1'b1}})) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
            if (mismatch && !first_err_valid) begin
                first_err_valid <= 1'b1;
                first_err_addr  <= addr_d;
            end
        end
    end

    always_comb begin
        err_count = '0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            err_count[i*CNT_W +: CNT_W] = cnt[i];
        end
    end

endmodule

// File: rtl/lenet_result_checker.sv
// On-chip LeNet self-check: measures compute latency with a watchdog, then
// streams the activation SRAM against the golden SRAM and reports per-region errors.
module lenet_result_checker
    import lenet_chk_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 16,
    parameter int NUM_REGIONS = 6,
    parameter int CNT_W       = 16,
    parameter int TIMEOUT     = DEFAULT_TIMEOUT
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          compute_start,
    input  logic                          compute_finish,
    input  logic [NUM_REGIONS*ADDR_W-1:0] region_end,
    output logic                          rd_en,
    output logic [ADDR_W-1:0]             act_addr,
    input  logic [DATA_W-1:0]             act_rdata,
    output logic [ADDR_W-1:0]             gold_addr,
    input  logic [DATA_W-1:0]             gold_rdata,
    output logic [31:0]                   cycle_count,
    output logic [NUM_REGIONS*CNT_W-1:0]  err_count,
    output logic                          first_err_valid,
    output logic [ADDR_W-1:0]             first_err_addr,
    output logic                          done,
    output logic                          pass,
    output logic                          timeout
);

    chk_state_t        state;
    chk_state_t        next_state;
    logic              start_run;
    logic [ADDR_W-1:0] scan_len;
    logic              scan_empty;
    logic              scan_last;
    logic              watchdog_hit;

    assign scan_len     = region_end[(NUM_REGIONS-1)*ADDR_W +: ADDR_W];
    assign scan_empty   = (scan_len == '0);
    assign scan_last    = (act_addr == (scan_len - 1'b1));
    assign watchdog_hit = (cycle_count == 32'(TIMEOUT - 1));
    assign gold_addr    = act_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Starts are honoured only while idle or holding a result; finish only while running.
    always_comb begin
        next_state = state;
        start_run  = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                if (compute_start) begin
                    next_state = RUN;
                    start_run  = 1'b1;
                end
            end
            RUN: begin
                if (compute_finish) begin
                    next_state = SCAN;
                end else if (watchdog_hit) begin
                    next_state = DONE;
                end
            end
            SCAN: begin
                if (scan_empty) begin
                    next_state = DONE;
                end else if (scan_last) begin
                    next_state = DRAIN;
                end
            end
            DRAIN:   next_state = DONE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_count <= '0;
            act_addr    <= '0;
            rd_en       <= 1'b0;
            done        <= 1'b0;
            timeout     <= 1'b0;
        end else if (start_run) begin
            cycle_count <= '0;
            act_addr    <= '0;
            rd_en       <= 1'b0;
            done        <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    cycle_count <= cycle_count + 1'b1;
                    if (compute_finish) begin
                        act_addr <= '0;
                        rd_en    <= !scan_empty;
                    end else if (watchdog_hit) begin
                        done    <= 1'b1;
                        timeout <= 1'b1;
                    end
                end
                SCAN: begin
                    if (scan_empty) begin
                        done <= 1'b1;
                    end else if (scan_last) begin
                        rd_en <= 1'b0;
                    end else begin
                        act_addr <= act_addr + 1'b1;
                    end
                end
                DRAIN: done <= 1'b1;
                default: ;
            endcase
        end
    end

    // The last compare retires on the same edge that raises done, so pass reads the live flag.
    assign pass = done && !timeout && !first_err_valid;

    chk_cmp_stage #(
        .DATA_W      (DATA_W),
        .ADDR_W      (ADDR_W),
        .NUM_REGIONS (NUM_REGIONS),
        .CNT_W       (CNT_W)
    ) u_cmp (
        .clk             (clk),
        .rst_n           (rst_n),
        .clear           (start_run),
        .rd_en           (rd_en),
        .addr            (act_addr),
        .region_end      (region_end),
        .act_rdata       (act_rdata),
        .gold_rdata      (gold_rdata),
        .err_count       (err_count),
        .first_err_valid (first_err_valid),
        .first_err_addr  (first_err_addr)
    );

endmodule

// File: tb/tb_lenet_result_checker.sv
// Scoreboard bench for lenet_result_checker: a reference model of the region
// compare predicts each run's results, which are popped when done rises.
module tb_lenet_result_checker;
    import lenet_chk_pkg::*;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 16;
    localparam int NR     = 6;
    localparam int CNT_W  = 16;

    typedef struct {
        logic [31:0]       cyc;
        logic [NR*CNT_W-1:0] errs;
        logic              fev;
        logic [ADDR_W-1:0] fea;
        logic              pass;
        int                lat;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rst_n;
    logic                   compute_start;
    logic                   compute_finish;
    logic [NR*ADDR_W-1:0]   region_end;
    logic                   rd_en;
    logic [ADDR_W-1:0]      act_addr;
    logic [ADDR_W-1:0]      gold_addr;
    logic [DATA_W-1:0]      act_rdata;
    logic [DATA_W-1:0]      gold_rdata;
    logic [31:0]            cycle_count;
    logic [NR*CNT_W-1:0]    err_count;
    logic                   first_err_valid;
    logic [ADDR_W-1:0]      first_err_addr;
    logic                   done;
    logic                   pass;
    logic                   timeout;

    logic                   wd_start;
    logic                   wd_rd_en;
    logic [ADDR_W-1:0]      wd_act_addr;
    logic [ADDR_W-1:0]      wd_gold_addr;
    logic [31:0]            wd_cycle_count;
    logic [NR*CNT_W-1:0]    wd_err_count;
    logic                   wd_fev;
    logic [ADDR_W-1:0]      wd_fea;
    logic                   wd_done;
    logic                   wd_pass;
    logic                   wd_timeout;

    logic [DATA_W-1:0] act_mem  [1024];
    logic [DATA_W-1:0] gold_mem [1024];

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   rd_cycles = 0;
    int   addr_errs = 0;
    int   wd_rd_cycles = 0;
    logic [ADDR_W-1:0] next_addr = '0;

    lenet_result_checker #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGIONS(NR), .CNT_W(CNT_W), .TIMEOUT(DEFAULT_TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .compute_start(compute_start), .compute_finish(compute_finish),
        .region_end(region_end), .rd_en(rd_en), .act_addr(act_addr), .act_rdata(act_rdata),
        .gold_addr(gold_addr), .gold_rdata(gold_rdata), .cycle_count(cycle_count),
        .err_count(err_count), .first_err_valid(first_err_valid), .first_err_addr(first_err_addr),
        .done(done), .pass(pass), .timeout(timeout)
    );

    lenet_result_checker #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGIONS(NR), .CNT_W(CNT_W), .TIMEOUT(100)
    ) dut_wd (
        .clk(clk), .rst_n(rst_n), .compute_start(wd_start), .compute_finish(1'b0),
        .region_end(DEFAULT_REGION_END), .rd_en(wd_rd_en), .act_addr(wd_act_addr), .act_rdata(32'h0),
        .gold_addr(wd_gold_addr), .gold_rdata(32'h0), .cycle_count(wd_cycle_count),
        .err_count(wd_err_count), .first_err_valid(wd_fev), .first_err_addr(wd_fea),
        .done(wd_done), .pass(wd_pass), .timeout(wd_timeout)
    );

    // SRAM models: one-cycle read latency.
    always @(posedge clk) begin
        if (rd_en) begin
            act_rdata  <= act_mem[act_addr[9:0]];
            gold_rdata <= gold_mem[gold_addr[9:0]];
        end
    end

    // Address monitor: scan addresses must run 0,1,2,... with gold_addr tracking act_addr.
    always @(negedge clk) begin
        if (rd_en) begin
            if (act_addr !== next_addr || gold_addr !== act_addr) addr_errs++;
            next_addr = act_addr + 1'b1;
            rd_cycles++;
        end else begin
            next_addr = '0;
        end
        if (wd_rd_en) wd_rd_cycles++;
    end

    function automatic exp_t model(input int finish_after);
        exp_t e;
        int lo;
        int hi;
        logic [CNT_W-1:0] c;
        e.cyc  = 32'(finish_after);
        e.errs = '0;
        e.fev  = 1'b0;
        e.fea  = '0;
        for (int r = 0; r < NR; r++) begin
            lo = (r == 0) ? 0 : int'(region_end[(r-1)*ADDR_W +: ADDR_W]);
            hi = int'(region_end[r*ADDR_W +: ADDR_W]);
            c  = '0;
            for (int a = lo; a < hi; a++) begin
                if (act_mem[a] !== gold_mem[a]) begin
                    if (c != '1) c = c + 1'b1;
                    if (!e.fev) begin
                        e.fev = 1'b1;
                        e.fea = ADDR_W'(a);
                    end
                end
            end
            e.errs[r*CNT_W +: CNT_W] = c;
        end
        e.pass = !e.fev;
        e.lat  = int'(region_end[(NR-1)*ADDR_W +: ADDR_W]) + 1;
        return e;
    endfunction

    task automatic fill_mem();
        for (int i = 0; i < 1024; i++) begin
            gold_mem[i] = (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000;
            act_mem[i]  = gold_mem[i];
        end
    endtask

    task automatic start_job();
        @(negedge clk) compute_start = 1'b1;
        @(negedge clk) compute_start = 1'b0;
    endtask

    // Raises finish so it is sampled finish_after edges after the start edge, then
    // waits (bounded) for done. lat = edges from the finish edge to the done edge.
    task automatic finish_job(input int finish_after, input int start_at, output int lat, output bit ok);
        repeat (finish_after - 1) @(negedge clk);
        compute_finish = 1'b1;
        lat = 0;
        ok  = 1'b0;
        for (int k = 1; k <= 5000; k++) begin
            @(negedge clk);
            compute_start = (k == start_at);
            if (done) begin
                lat = k - 1;
                ok  = 1'b1;
                break;
            end
        end
        compute_finish = 1'b0;
        compute_start  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (done !== 1'b0 || pass !== 1'b0 || timeout !== 1'b0) begin errors++; $display("[TB] FAIL reset_flags got=%b%b%b want=000", done, pass, timeout); end
        checks++; if (rd_en !== 1'b0 || act_addr !== '0 || gold_addr !== '0) begin errors++; $display("[TB] FAIL reset_addr got rd_en=%b addr=%0d/%0d want 0", rd_en, act_addr, gold_addr); end
        checks++; if (cycle_count !== '0 || err_count !== '0 || first_err_valid !== 1'b0 || first_err_addr !== '0) begin errors++; $display("[TB] FAIL reset_results got cyc=%0d errs=%h fev=%b fea=%0d want 0", cycle_count, err_count, first_err_valid, first_err_addr); end
        checks++; if (wd_done !== 1'b0 || wd_timeout !== 1'b0 || wd_cycle_count !== '0) begin errors++; $display("[TB] FAIL reset_wd got done=%b tmo=%b cyc=%0d want 0", wd_done, wd_timeout, wd_cycle_count); end
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_match();
        exp_t e;
        int lat;
        bit ok;
        fill_mem();
        region_end = DEFAULT_REGION_END;
        rd_cycles = 0;
        addr_errs = 0;
        sb.push_back(model(500));
        start_job();
        finish_job(500, 0, lat, ok);
        e = sb.pop_front();
        checks++; if (!ok) begin errors++; $display("[TB] FAIL match_done_seen got=0 want=1"); end
        checks++; if (lat !== e.lat) begin errors++; $display("[TB] FAIL match_latency got=%0d want=%0d", lat, e.lat); end
        checks++; if (cycle_count !== e.cyc) begin errors++; $display("[TB] FAIL match_cycle_count got=%0d want=%0d", cycle_count, e.cyc); end
        checks++; if (err_count !== e.errs) begin errors++; $display("[TB] FAIL match_err_count got=%h want=%h", err_count, e.errs); end
        checks++; if (pass !== e.pass || timeout !== 1'b0) begin errors++; $display("[TB] FAIL match_pass got pass=%b tmo=%b want pass=%b tmo=0", pass, timeout, e.pass); end
        checks++; if (rd_cycles !== 753 || addr_errs !== 0) begin errors++; $display("[TB] FAIL match_scan_addrs got reads=%0d bad=%0d want reads=753 bad=0", rd_cycles, addr_errs); end
    endtask

    task automatic test_corrupt();
        exp_t e;
        int lat;
        bit ok;
        fill_mem();
        act_mem[300] = act_mem[300] ^ 32'h0000_0001;
        act_mem[700] = act_mem[700] ^ 32'h8000_0000;
        region_end = DEFAULT_REGION_END;
        sb.push_back(model(120));
        start_job();
        finish_job(120, 0, lat, ok);
        e = sb.pop_front();
        checks++; if (!ok || lat !== e.lat) begin errors++; $display("[TB] FAIL corrupt_latency got ok=%b lat=%0d want lat=%0d", ok, lat, e.lat); end
        checks++; if (err_count !== e.errs) begin errors++; $display("[TB] FAIL corrupt_err_count got=%h want=%h", err_count, e.errs); end
        checks++; if (err_count[1*CNT_W +: CNT_W] !== 16'd1 || err_count[3*CNT_W +: CNT_W] !== 16'd1) begin errors++; $display("[TB] FAIL corrupt_regions13 got=%0d,%0d want=1,1", err_count[1*CNT_W +: CNT_W], err_count[3*CNT_W +: CNT_W]); end
        checks++; if (first_err_valid !== e.fev || first_err_addr !== e.fea) begin errors++; $display("[TB] FAIL corrupt_first_err got v=%b a=%0d want v=%b a=%0d", first_err_valid, first_err_addr, e.fev, e.fea); end
        checks++; if (pass !== e.pass || done !== 1'b1) begin errors++; $display("[TB] FAIL corrupt_pass got pass=%b done=%b want pass=%b done=1", pass, done, e.pass); end
    endtask

    task automatic test_timeout();
        int k;
        bit seen;
        seen = 1'b0;
        k = 0;
        @(negedge clk) wd_start = 1'b1;
        @(negedge clk) wd_start = 1'b0;
        wd_rd_cycles = 0;
        for (int i = 1; i <= 1000; i++) begin
            @(negedge clk);
            if (wd_done) begin
                k = i;
                seen = 1'b1;
                break;
            end
        end
        checks++; if (!seen || k !== 100) begin errors++; $display("[TB] FAIL wd_done_cycle got seen=%b cycles=%0d want cycles=100", seen, k); end
        checks++; if (wd_timeout !== 1'b1 || wd_pass !== 1'b0) begin errors++; $display("[TB] FAIL wd_flags got tmo=%b pass=%b want tmo=1 pass=0", wd_timeout, wd_pass); end
        repeat (5) @(negedge clk);
        checks++; if (wd_done !== 1'b1 || wd_rd_cycles !== 0 || wd_err_count !== '0) begin errors++; $display("[TB] FAIL wd_hold got done=%b reads=%0d errs=%h want done=1 reads=0 errs=0", wd_done, wd_rd_cycles, wd_err_count); end
    endtask

    task automatic test_regions();
        exp_t e;
        int lat;
        bit ok;
        fill_mem();
        for (int i = 0; i < 8; i++) act_mem[i] = ~gold_mem[i];
        region_end = {16'd8, 16'd4, 16'd4, 16'd4, 16'd0, 16'd0};
        e.cyc  = 32'd20;
        e.errs = {16'd4, 16'd0, 16'd0, 16'd4, 16'd0, 16'd0};
        e.fev  = 1'b1;
        e.fea  = '0;
        e.pass = 1'b0;
        e.lat  = 9;
        sb.push_back(e);
        start_job();
        finish_job(20, 0, lat, ok);
        e = sb.pop_front();
        checks++; if (!ok || lat !== e.lat) begin errors++; $display("[TB] FAIL regions_latency got ok=%b lat=%0d want lat=%0d", ok, lat, e.lat); end
        checks++; if (err_count !== e.errs) begin errors++; $display("[TB] FAIL regions_err_count got=%h want=%h", err_count, e.errs); end
        checks++; if (first_err_addr !== e.fea || pass !== e.pass || cycle_count !== e.cyc) begin errors++; $display("[TB] FAIL regions_summary got fea=%0d pass=%b cyc=%0d want fea=0 pass=0 cyc=20", first_err_addr, pass, cycle_count); end
        region_end = '0;
        rd_cycles = 0;
        sb.push_back(model(10));
        start_job();
        finish_job(10, 0, lat, ok);
        e = sb.pop_front();
        checks++; if (!ok || lat !== e.lat || pass !== 1'b1) begin errors++; $display("[TB] FAIL empty_scan got ok=%b lat=%0d pass=%b want lat=%0d pass=1", ok, lat, pass, e.lat); end
        checks++; if (rd_cycles !== 0 || err_count !== '0) begin errors++; $display("[TB] FAIL empty_scan_reads got reads=%0d errs=%h want 0", rd_cycles, err_count); end
    endtask

    task automatic test_reset_mid_scan();
        exp_t e;
        int lat;
        bit ok;
        fill_mem();
        act_mem[50] = ~gold_mem[50];
        region_end = DEFAULT_REGION_END;
        start_job();
        repeat (99) @(negedge clk);
        compute_finish = 1'b1;
        repeat (100) @(negedge clk);
        checks++; if (rd_en !== 1'b1 || first_err_valid !== 1'b1) begin errors++; $display("[TB] FAIL midscan_active got rd_en=%b fev=%b want 1,1", rd_en, first_err_valid); end
        rst_n = 1'b0;
        #1;
        checks++; if ({rd_en, act_addr, gold_addr, done, pass, timeout} !== '0) begin errors++; $display("[TB] FAIL midscan_reset_ctrl got rd_en=%b addr=%0d done=%b pass=%b tmo=%b want 0", rd_en, act_addr, done, pass, timeout); end
        checks++; if ({cycle_count, err_count, first_err_valid, first_err_addr} !== '0) begin errors++; $display("[TB] FAIL midscan_reset_results got cyc=%0d errs=%h fev=%b want 0", cycle_count, err_count, first_err_valid); end
        compute_finish = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        fill_mem();
        sb.push_back(model(50));
        start_job();
        finish_job(50, 0, lat, ok);
        e = sb.pop_front();
        checks++; if (!ok || lat !== e.lat || cycle_count !== e.cyc) begin errors++; $display("[TB] FAIL after_reset_run got ok=%b lat=%0d cyc=%0d want lat=%0d cyc=%0d", ok, lat, cycle_count, e.lat, e.cyc); end
        checks++; if (pass !== e.pass || err_count !== e.errs) begin errors++; $display("[TB] FAIL after_reset_pass got pass=%b errs=%h want pass=%b", pass, err_count, e.pass); end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int lat;
        bit ok;
        fill_mem();
        act_mem[10]  = act_mem[10] ^ 32'h00F0_0000;
        act_mem[600] = act_mem[600] ^ 32'h0000_0100;
        region_end = DEFAULT_REGION_END;
        sb.push_back(model(30));
        start_job();
        finish_job(30, 0, lat, ok);
        e = sb.pop_front();
        checks++; if (!ok || err_count !== e.errs || pass !== e.pass) begin errors++; $display("[TB] FAIL b2b_first got ok=%b errs=%h pass=%b want errs=%h pass=%b", ok, err_count, pass, e.errs, e.pass); end
        start_job();
        checks++; if (done !== 1'b0 || pass !== 1'b0 || timeout !== 1'b0) begin errors++; $display("[TB] FAIL b2b_clear_flags got done=%b pass=%b tmo=%b want 0", done, pass, timeout); end
        checks++; if (err_count !== '0 || first_err_valid !== 1'b0 || first_err_addr !== '0 || cycle_count !== '0) begin errors++; $display("[TB] FAIL b2b_clear_results got errs=%h fev=%b fea=%0d cyc=%0d want 0", err_count, first_err_valid, first_err_addr, cycle_count); end
        sb.push_back(model(40));
        finish_job(40, 200, lat, ok);
        e = sb.pop_front();
        checks++; if (!ok || lat !== e.lat || cycle_count !== e.cyc) begin errors++; $display("[TB] FAIL b2b_ignore_start got ok=%b lat=%0d cyc=%0d want lat=%0d cyc=%0d", ok, lat, cycle_count, e.lat, e.cyc); end
        checks++; if (err_count !== e.errs || first_err_addr !== e.fea) begin errors++; $display("[TB] FAIL b2b_counts got errs=%h fea=%0d want errs=%h fea=%0d", err_count, first_err_addr, e.errs, e.fea); end
    endtask

    initial begin
        rst_n          = 1'b0;
        compute_start  = 1'b0;
        compute_finish = 1'b0;
        wd_start       = 1'b0;
        region_end     = DEFAULT_REGION_END;
        fill_mem();
        test_reset();
        test_match();
        test_corrupt();
        test_timeout();
        test_regions();
        test_reset_mid_scan();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
